// File: rtl/cci_mpf_fiu_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : cci_mpf_fiu_responder_if
// Brief   : MPF-to-FIU TX request / RX response bundle for the FIU responder.
// Revision: 1.0 - initial release
// ============================================================================
interface cci_mpf_fiu_responder_if #(
    parameter int ADDR_W     = 42,
    parameter int MDATA_W    = 16,
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 64
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               c0tx_valid;
    logic [ADDR_W-1:0]  c0tx_addr;
    logic [MDATA_W-1:0] c0tx_mdata;
    logic               c1tx_valid;
    logic               c1tx_sop;
    logic [ADDR_W-1:0]  c1tx_addr;
    logic [MDATA_W-1:0] c1tx_mdata;
    logic               c0tx_almfull;
    logic               c1tx_almfull;
    logic               c0rx_valid;
    logic [MDATA_W-1:0] c0rx_mdata;
    logic [DATA_W-1:0]  c0rx_data;
    logic               c1rx_valid;
    logic [MDATA_W-1:0] c1rx_mdata;
    logic [CNT_W-1:0]   c0_active;
    logic [CNT_W-1:0]   c1_active;
    logic [1:0]         ovf_err;

    modport slave (
        input  c0tx_valid, c0tx_addr, c0tx_mdata,
        input  c1tx_valid, c1tx_sop, c1tx_addr, c1tx_mdata,
        output c0tx_almfull, c1tx_almfull,
        output c0rx_valid, c0rx_mdata, c0rx_data,
        output c1rx_valid, c1rx_mdata,
        output c0_active, c1_active, ovf_err
    );

    modport master (
        output c0tx_valid, c0tx_addr, c0tx_mdata,
        output c1tx_valid, c1tx_sop, c1tx_addr, c1tx_mdata,
        input  c0tx_almfull, c1tx_almfull,
        input  c0rx_valid, c0rx_mdata, c0rx_data,
        input  c1rx_valid, c1rx_mdata,
        input  c0_active, c1_active, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/cci_mpf_fiu_responder.sv
`default_nettype none
// ============================================================================
// Module  : cci_mpf_fiu_responder
// Brief   : FIU-side responder; returns read/write responses after a fixed
//           minimum latency through per-channel timestamped FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
module cci_mpf_fiu_responder_chan #(
    parameter int PLD_W   = 16,
    parameter int DEPTH   = 64,
    parameter int SLACK   = 8,
    parameter int LATENCY = 32,
    parameter int TS_W    = 8,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [TS_W-1:0]  ts,
    input  logic             push,
    input  logic [PLD_W-1:0] push_pld,
    output logic             pop,
    output logic [PLD_W-1:0] head_pld,
    output logic [CNT_W-1:0] count,
    output logic             almfull,
    output logic             ovf
);
    localparam int               c_ptr_w   = $clog2(DEPTH);
    localparam logic [TS_W-1:0]  c_lat_m1  = TS_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_alm_thr = CNT_W'(DEPTH - SLACK);

    logic [PLD_W-1:0]   r_pld   [DEPTH];
    logic [TS_W-1:0]    r_stamp [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_almfull;
    logic               r_ovf;

    logic [TS_W-1:0]    w_age;
    logic               w_pop;
    logic               w_accept;
    logic [CNT_W-1:0]   w_count_nxt;

    // Age is taken modulo the timestamp width so the check survives ts wrap.
    always_comb begin
        w_age       = ts - r_stamp[r_rd_ptr];
        w_pop       = (r_count != '0) && (w_age >= c_lat_m1);
        w_accept    = push && ((r_count != c_depth) || w_pop);
        w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pld[r_wr_ptr]   <= push_pld;
            r_stamp[r_wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_almfull <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= w_count_nxt;
            r_almfull <= (w_count_nxt >= c_alm_thr);
            if (push && !w_accept) r_ovf <= 1'b1;
        end
    end

    assign pop      = w_pop;
    assign head_pld = r_pld[r_rd_ptr];
    assign count    = r_count;
    assign almfull  = r_almfull;
    assign ovf      = r_ovf;
endmodule

module cci_mpf_fiu_responder #(
    parameter int ADDR_W        = 42,
    parameter int MDATA_W       = 16,
    parameter int DATA_W        = 512,
    parameter int FIFO_DEPTH    = 64,
    parameter int ALMFULL_SLACK = 8,
    parameter int RD_LATENCY    = 32,
    parameter int WR_LATENCY    = 16,
    parameter int TS_W          = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cci_mpf_fiu_responder_if.slave bus
);
    localparam int          c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int          c_c0_w    = ADDR_W + MDATA_W;
    localparam logic [63:0] c_pattern = 64'hA5A5_0000_0000_0000;

    logic [TS_W-1:0]    r_ts;
    logic               w_c0_pop;
    logic               w_c1_pop;
    logic [c_c0_w-1:0]  w_c0_head;
    logic [MDATA_W-1:0] w_c1_head;
    logic [63:0]        w_c0_lane;
    logic [c_cnt_w-1:0] w_c0_count;
    logic [c_cnt_w-1:0] w_c1_count;
    logic               w_c0_almfull;
    logic               w_c1_almfull;
    logic               w_c0_ovf;
    logic               w_c1_ovf;

    logic               r_c0rx_valid;
    logic [MDATA_W-1:0] r_c0rx_mdata;
    logic [DATA_W-1:0]  r_c0rx_data;
    logic               r_c1rx_valid;
    logic [MDATA_W-1:0] r_c1rx_mdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ts <= '0;
        else          r_ts <= r_ts + 1'b1;
    end

    cci_mpf_fiu_responder_chan #(
        .PLD_W(c_c0_w), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK),
        .LATENCY(RD_LATENCY), .TS_W(TS_W), .CNT_W(c_cnt_w)
    ) u_c0 (
        .clk(clk), .reset_n(reset_n), .ts(r_ts),
        .push(bus.c0tx_valid), .push_pld({bus.c0tx_addr, bus.c0tx_mdata}),
        .pop(w_c0_pop), .head_pld(w_c0_head), .count(w_c0_count),
        .almfull(w_c0_almfull), .ovf(w_c0_ovf)
    );

    // Only the sop flit of a write packet creates a response entry.
    cci_mpf_fiu_responder_chan #(
        .PLD_W(MDATA_W), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK),
        .LATENCY(WR_LATENCY), .TS_W(TS_W), .CNT_W(c_cnt_w)
    ) u_c1 (
        .clk(clk), .reset_n(reset_n), .ts(r_ts),
        .push(bus.c1tx_valid && bus.c1tx_sop), .push_pld(bus.c1tx_mdata),
        .pop(w_c1_pop), .head_pld(w_c1_head), .count(w_c1_count),
        .almfull(w_c1_almfull), .ovf(w_c1_ovf)
    );

    assign w_c0_lane = 64'(w_c0_head[c_c0_w-1:MDATA_W]) ^ c_pattern;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_c0rx_valid <= 1'b0;
            r_c0rx_mdata <= '0;
            r_c0rx_data  <= '0;
            r_c1rx_valid <= 1'b0;
            r_c1rx_mdata <= '0;
        end else begin
            r_c0rx_valid <= w_c0_pop;
            r_c1rx_valid <= w_c1_pop;
            if (w_c0_pop) begin
                r_c0rx_mdata <= w_c0_head[MDATA_W-1:0];
                r_c0rx_data  <= {(DATA_W/64){w_c0_lane}};
            end
            if (w_c1_pop) r_c1rx_mdata <= w_c1_head;
        end
    end

    assign bus.c0rx_valid   = r_c0rx_valid;
    assign bus.c0rx_mdata   = r_c0rx_mdata;
    assign bus.c0rx_data    = r_c0rx_data;
    assign bus.c1rx_valid   = r_c1rx_valid;
    assign bus.c1rx_mdata   = r_c1rx_mdata;
    assign bus.c0tx_almfull = w_c0_almfull;
    assign bus.c1tx_almfull = w_c1_almfull;
    assign bus.c0_active    = w_c0_count;
    assign bus.c1_active    = w_c1_count;
    assign bus.ovf_err      = {w_c1_ovf, w_c0_ovf};
endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_fiu_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cci_mpf_fiu_responder
// Brief   : Scoreboard bench: a queue-based response model predicts each rx
//           pulse; a negedge monitor compares whatever the DUT presents.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cci_mpf_fiu_responder;
    localparam int ADDR_W  = 42;
    localparam int MDATA_W = 16;
    localparam int DATA_W  = 512;
    localparam int DEPTH   = 64;
    localparam int SLACK   = 8;
    localparam int RD_LAT  = 100;
    localparam int WR_LAT  = 90;
    localparam int TS_W    = 8;

    typedef struct {
        int                 due;
        logic [MDATA_W-1:0] mdata;
        logic [DATA_W-1:0]  data;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cci_mpf_fiu_responder_if #(
        .ADDR_W(ADDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) bus ();

    cci_mpf_fiu_responder #(
        .ADDR_W(ADDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
        .ALMFULL_SLACK(SLACK), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    int   exp_c0_active = 0;
    int   exp_c1_active = 0;
    logic exp_c0_alm = 1'b0;
    logic exp_c1_alm = 1'b0;
    logic [1:0] exp_ovf = 2'b00;
    logic [MDATA_W-1:0] last0 = '0;
    logic [MDATA_W-1:0] last1 = '0;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [63:0]       lane;
        logic [DATA_W-1:0] d;
        lane = {{(64-ADDR_W){1'b0}}, a} ^ 64'hA5A5_0000_0000_0000;
        for (int i = 0; i < DATA_W / 64; i++) d[i*64 +: 64] = lane;
        return d;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: response due at accept edge + LAT - 1, never earlier
    // than one edge after the previous response on the same channel.
    always @(posedge clk) begin : model
        exp_t e;
        int   due;
        logic p0;
        logic p1;
        edge_n++;
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            exp_c0_active = 0;
            exp_c1_active = 0;
            exp_c0_alm    = 1'b0;
            exp_c1_alm    = 1'b0;
            exp_ovf       = 2'b00;
            last0         = '0;
            last1         = '0;
        end else begin
            p0 = (q0.size() > 0) && (q0[0].due == edge_n);
            p1 = (q1.size() > 0) && (q1[0].due == edge_n);
            if (bus.c0tx_valid) begin
                if (q0.size() >= DEPTH && !p0) exp_ovf[0] = 1'b1;
                else begin
                    due = edge_n + RD_LAT - 1;
                    if (q0.size() > 0 && q0[$].due >= due) due = q0[$].due + 1;
                    e.due = due; e.mdata = bus.c0tx_mdata; e.data = pattern(bus.c0tx_addr);
                    q0.push_back(e);
                end
            end
            if (bus.c1tx_valid && bus.c1tx_sop) begin
                if (q1.size() >= DEPTH && !p1) exp_ovf[1] = 1'b1;
                else begin
                    due = edge_n + WR_LAT - 1;
                    if (q1.size() > 0 && q1[$].due >= due) due = q1[$].due + 1;
                    e.due = due; e.mdata = bus.c1tx_mdata; e.data = '0;
                    q1.push_back(e);
                end
            end
            exp_c0_active = q0.size() - (p0 ? 1 : 0);
            exp_c1_active = q1.size() - (p1 ? 1 : 0);
            exp_c0_alm    = (exp_c0_active >= DEPTH - SLACK);
            exp_c1_alm    = (exp_c1_active >= DEPTH - SLACK);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        logic v0;
        logic v1;
        v0 = (q0.size() > 0) && (q0[0].due == edge_n);
        v1 = (q1.size() > 0) && (q1[0].due == edge_n);
        check("c0rx_valid", bus.c0rx_valid, v0);
        if (v0) begin
            e = q0.pop_front();
            last0 = e.mdata;
            check("c0rx_mdata", bus.c0rx_mdata, e.mdata);
            check("c0rx_data", bus.c0rx_data, e.data);
        end else check("c0rx_mdata_hold", bus.c0rx_mdata, last0);
        check("c1rx_valid", bus.c1rx_valid, v1);
        if (v1) begin
            e = q1.pop_front();
            last1 = e.mdata;
            check("c1rx_mdata", bus.c1rx_mdata, e.mdata);
        end else check("c1rx_mdata_hold", bus.c1rx_mdata, last1);
        while (q0.size() > 0 && q0[0].due <= edge_n) void'(q0.pop_front());
        while (q1.size() > 0 && q1[0].due <= edge_n) void'(q1.pop_front());
        check("c0_active", bus.c0_active, exp_c0_active);
        check("c1_active", bus.c1_active, exp_c1_active);
        check("c0tx_almfull", bus.c0tx_almfull, exp_c0_alm);
        check("c1tx_almfull", bus.c1tx_almfull, exp_c1_alm);
        check("ovf_err", bus.ovf_err, exp_ovf);
    end

    task automatic set_idle();
        bus.c0tx_valid = 1'b0;
        bus.c0tx_addr  = '0;
        bus.c0tx_mdata = '0;
        bus.c1tx_valid = 1'b0;
        bus.c1tx_sop   = 1'b0;
        bus.c1tx_addr  = '0;
        bus.c1tx_mdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        #2 reset_n = 1'b0;
        #1;
        check("rst_c0rx_valid", bus.c0rx_valid, 0);
        check("rst_c1rx_valid", bus.c1rx_valid, 0);
        check("rst_c0_active", bus.c0_active, 0);
        check("rst_c1_active", bus.c1_active, 0);
        check("rst_almfull", {bus.c1tx_almfull, bus.c0tx_almfull}, 0);
        check("rst_ovf_err", bus.ovf_err, 0);
        check("rst_c0rx_data", bus.c0rx_data, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic drive_read(input logic [ADDR_W-1:0] a, input logic [MDATA_W-1:0] m);
        bus.c0tx_valid = 1'b1;
        bus.c0tx_addr  = a;
        bus.c0tx_mdata = m;
    endtask

    task automatic drive_write(input logic sop, input logic [MDATA_W-1:0] m);
        bus.c1tx_valid = 1'b1;
        bus.c1tx_sop   = sop;
        bus.c1tx_addr  = ADDR_W'($urandom());
        bus.c1tx_mdata = m;
    endtask

    initial begin : stim
        int t;
        int pulses;
        logic [DATA_W-1:0] want;
        set_idle();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        do_reset();

        // Single read: one pulse RD_LAT-1 negedges after the accept edge.
        @(negedge clk);
        drive_read(ADDR_W'(42'h1234), 16'h00AB);
        @(negedge clk);
        set_idle();
        t = 0;
        while (!bus.c0rx_valid && t < 300) begin @(negedge clk); t++; end
        check("rd_latency", t, RD_LAT - 1);
        check("rd_mdata", bus.c0rx_mdata, 16'h00AB);
        for (int i = 0; i < DATA_W / 64; i++) want[i*64 +: 64] = 64'hA5A5_0000_0000_1234;
        check("rd_data", bus.c0rx_data, want);
        @(negedge clk);
        check("rd_single_pulse", bus.c0rx_valid, 0);

        // 4-flit write: only the sop flit yields an entry.
        @(negedge clk);
        drive_write(1'b1, 16'h0007);
        for (int f = 1; f < 4; f++) begin
            @(negedge clk);
            check("wr_active_one", bus.c1_active, 1);
            drive_write(1'b0, 16'h0099);
        end
        @(negedge clk);
        set_idle();
        t = 3;
        while (!bus.c1rx_valid && t < 300) begin @(negedge clk); t++; end
        check("wr_latency", t, WR_LAT - 1);
        check("wr_mdata", bus.c1rx_mdata, 16'h0007);
        @(negedge clk);
        check("wr_single_pulse", bus.c1rx_valid, 0);
        check("wr_active_zero", bus.c1_active, 0);

        // Randomized mixed traffic spanning many timestamp wraps.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            set_idle();
            if ($urandom_range(0, 1) == 1)
                drive_read(ADDR_W'({$urandom(), $urandom()}), MDATA_W'($urandom()));
            if ($urandom_range(0, 2) != 0)
                drive_write($urandom_range(0, 1) == 1, MDATA_W'($urandom()));
        end
        @(negedge clk);
        set_idle();
        repeat (250) @(negedge clk);
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        // Fill c0 to full, overflow, then keep reading through the first pops.
        do_reset();
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            drive_read(ADDR_W'(i), MDATA_W'(i));
            @(posedge clk);
            #1;
            if (i <= 65) begin
                check("fill_c0_active", bus.c0_active, (i > DEPTH) ? DEPTH : i);
                check("fill_c0_almfull", bus.c0tx_almfull, (i >= DEPTH - SLACK));
            end
            if (i == 65) check("fill_ovf", bus.ovf_err, 2'b01);
        end
        check("full_pop_active", bus.c0_active, DEPTH);
        @(negedge clk);
        set_idle();
        repeat (250) @(negedge clk);
        check("ovf_sticky", bus.ovf_err, 2'b01);

        // c1 overflow from sop flits; reset must have cleared c0's flag.
        do_reset();
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk);
            drive_write(1'b1, MDATA_W'(i));
        end
        @(negedge clk);
        set_idle();
        check("c1_full_active", bus.c1_active, DEPTH);
        check("c1_ovf", bus.ovf_err, 2'b10);
        repeat (200) @(negedge clk);

        // Mid-operation reset with reads pending: nothing may come back.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_read(ADDR_W'($urandom()), MDATA_W'(16'h5000 + i));
        end
        @(negedge clk);
        set_idle();
        repeat (5) @(negedge clk);
        check("pre_rst_active", bus.c0_active, 10);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 2 * RD_LAT; i++) begin
            @(negedge clk);
            if (bus.c0rx_valid) pulses++;
        end
        check("post_rst_pulses", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
